// File: rtl/fft_peak_collector.sv
// fft_peak_collector: reduces each serialized FFT frame to its peak bin.
// Ports: clk, reset (async, active-low), recv_* bin stream in, send_* peak (idx, |mag|) out.
module fft_peak_collector #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8,
   parameter int SKIP_DC   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [BIT_WIDTH-1:0]         recv_msg,
   input  logic                         recv_val,
   output logic                         recv_rdy,
   output logic [$clog2(N_SAMPLES)-1:0] send_idx,
   output logic [BIT_WIDTH-1:0]         send_mag,
   output logic                         send_val,
   input  logic                         send_rdy
);

   localparam int IW = $clog2(N_SAMPLES);
   localparam logic [BIT_WIDTH-1:0] MOST_NEG =
      {1'b1, {(BIT_WIDTH-1){1'b0}}};
   localparam logic [BIT_WIDTH-1:0] MOST_POS =
      {1'b0, {(BIT_WIDTH-1){1'b1}}};
   localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t               state;
   state_t               state_next;
   logic [IW-1:0]        count;
   logic [IW-1:0]        best_idx;
   logic [BIT_WIDTH-1:0] best_mag;
   logic                 have_best;
   logic [BIT_WIDTH-1:0] mag;
   logic                 xfer;
   logic                 last_bin;
   logic                 is_cand;
   logic                 take;

   // |x| with the most negative code clamped so the result never wraps
   always_comb begin
      mag = recv_msg;
      if (recv_msg[BIT_WIDTH-1]) begin
         if (recv_msg == MOST_NEG) mag = MOST_POS;
         else                      mag = -recv_msg;
      end
   end

   assign xfer     = recv_val && (state == ACCUM);
   assign last_bin = (count == LAST_IDX);
   assign is_cand  = !((SKIP_DC != 0) && (count == '0));
   // strict compare keeps the lowest index on ties
   assign take     = xfer && is_cand &&
                     (!have_best || (mag > best_mag));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ACCUM;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      recv_rdy   = 1'b0;
      send_val   = 1'b0;
      unique case (state)
         ACCUM: begin
            recv_rdy = 1'b1;
            if (recv_val && last_bin) state_next = DONE;
         end
         DONE: begin
            send_val = 1'b1;
            if (send_rdy) state_next = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         have_best <= 1'b0;
         best_idx  <= '0;
         best_mag  <= '0;
      end else if (xfer) begin
         if (take) begin
            best_idx <= count;
            best_mag <= mag;
         end
         if (last_bin) begin
            count     <= '0;
            have_best <= 1'b0;
         end else begin
            count <= count + IW'(1);
            if (is_cand) have_best <= 1'b1;
         end
      end
   end

   assign send_idx = best_idx;
   assign send_mag = best_mag;

endmodule

// File: tb/tb_fft_peak_collector.sv
// tb_fft_peak_collector: self-checking bench for fft_peak_collector.
// Directed frames plus randomized gaps/stalls against a behavioural model.
module tb_fft_peak_collector;

   localparam int W    = 32;
   localparam int N    = 8;
   localparam int SKIP = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  recv_msg;
   logic          recv_val;
   logic          recv_rdy;
   logic [2:0]    send_idx;
   logic [W-1:0]  send_mag;
   logic          send_val;
   logic          send_rdy;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] fr [N];

   fft_peak_collector #(
      .BIT_WIDTH(W),
      .N_SAMPLES(N),
      .SKIP_DC(SKIP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .recv_msg(recv_msg),
      .recv_val(recv_val),
      .recv_rdy(recv_rdy),
      .send_idx(send_idx),
      .send_mag(send_mag),
      .send_val(send_val),
      .send_rdy(send_rdy)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [W-1:0] b [N],
                                 output logic [2:0] idx,
                                 output logic [W-1:0] mag);
      longint best;
      longint a;
      longint v;
      best = -1;
      idx  = 3'd0;
      for (int i = SKIP; i < N; i++) begin
         v = longint'($signed(b[i]));
         a = (v < 0) ? -v : v;
         if (a > 64'h7FFF_FFFF) a = 64'h7FFF_FFFF;
         if (best < 0 || a > best) begin
            best = a;
            idx  = 3'(i);
         end
      end
      mag = W'(best);
   endfunction

   function automatic logic [W-1:0] rand_bin();
      logic [W-1:0] k;
      case ($urandom_range(0, 5))
         0: return W'($urandom);
         1: return 32'h8000_0000;
         2: return 32'h0;
         default: begin
            k = W'($urandom_range(0, 7)) << 16;
            if ($urandom_range(0, 1) == 1) k = -k;
            return k;
         end
      endcase
   endfunction

   task automatic send_frame();
      for (int i = 0; i < N; i++) begin
         recv_val = 1'b1;
         recv_msg = fr[i];
         @(posedge clk);
         #1;
      end
      recv_val = 1'b0;
   endtask

   task automatic wait_result(output bit got);
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (send_val) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic accept();
      send_rdy = 1'b1;
      @(posedge clk);
      #1;
      send_rdy = 1'b0;
   endtask

   task automatic check_frame(input string name,
                              input logic [2:0] ei,
                              input logic [W-1:0] em);
      bit got;
      wait_result(got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: send_val never rose", name);
      end else begin
         checks++;
         if (send_idx !== ei || send_mag !== em) begin
            errors++;
            $display("FAIL %s: got idx=%0d mag=%h, want idx=%0d mag=%h",
                     name, send_idx, send_mag, ei, em);
         end
         accept();
      end
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      recv_val = 1'b0;
      recv_msg = '0;
      send_rdy = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) reset = 1'b1;
         checks++;
         if (recv_rdy !== 1'b1 || send_val !== 1'b0 ||
             send_idx !== 3'd0 || send_mag !== '0) begin
            errors++;
            $display("FAIL reset c%0d: rdy=%b val=%b idx=%0d mag=%h, want 1 0 0 0",
                     c, recv_rdy, send_val, send_idx, send_mag);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_basic();
      fr = '{32'h0010_0000, 32'h0001_0000, 32'hFFFB_0000, 32'h0002_0000,
             32'h0, 32'h0, 32'h0003_0000, 32'h0};
      send_frame();
      checks++;
      if (send_val !== 1'b1 || recv_rdy !== 1'b0) begin
         errors++;
         $display("FAIL basic latency: val=%b rdy=%b, want 1 0",
                  send_val, recv_rdy);
      end
      check_frame("basic", 3'd2, 32'h0005_0000);
      checks++;
      if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
         errors++;
         $display("FAIL basic release: val=%b rdy=%b, want 0 1",
                  send_val, recv_rdy);
      end
   endtask

   task automatic test_tie();
      fr = '{32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0004_0000,
             32'h0, 32'h0004_0000, 32'hFFFD_0000, 32'h0};
      send_frame();
      check_frame("tie", 3'd3, 32'h0004_0000);
      fr = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      send_frame();
      check_frame("all_zero", 3'd1, 32'h0);
   endtask

   task automatic test_saturation();
      fr = '{32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFF0, 32'h0,
             32'h0, 32'h0, 32'h8000_0000, 32'h0};
      send_frame();
      check_frame("sat", 3'd6, 32'h7FFF_FFFF);
      fr = '{32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h8000_0000, 32'h0};
      send_frame();
      check_frame("sat_tie", 3'd1, 32'h7FFF_FFFF);
   endtask

   task automatic test_backpressure();
      fr = '{32'h0, 32'h0, 32'h0, 32'h0,
             32'h0, 32'hFFF8_0000, 32'h0001_0000, 32'h0};
      send_frame();
      for (int c = 0; c < 10; c++) begin
         recv_val = 1'b1;
         recv_msg = 32'h7FFF_0000;
         @(posedge clk);
         #1;
         checks++;
         if (recv_rdy !== 1'b0 || send_val !== 1'b1 ||
             send_idx !== 3'd5 || send_mag !== 32'h0008_0000) begin
            errors++;
            $display("FAIL bp hold c%0d: rdy=%b val=%b idx=%0d mag=%h, want 0 1 5 00080000",
                     c, recv_rdy, send_val, send_idx, send_mag);
         end
      end
      send_rdy = 1'b1;
      recv_msg = 32'h0;
      @(posedge clk);
      #1;
      send_rdy = 1'b0;
      checks++;
      if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
         errors++;
         $display("FAIL bp release: rdy=%b val=%b, want 1 0",
                  recv_rdy, send_val);
      end
      fr = '{32'h0, 32'h0002_0000, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 32'hFFFF_0000};
      send_frame();
      checks++;
      if (send_val !== 1'b1) begin
         errors++;
         $display("FAIL bp next latency: val=%b, want 1", send_val);
      end
      check_frame("bp_next", 3'd1, 32'h0002_0000);
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 5; i++) begin
         recv_val = 1'b1;
         recv_msg = (i == 2) ? 32'h7FFF_0000 : 32'h0050_0000;
         @(posedge clk);
         #1;
      end
      recv_val = 1'b0;
      reset    = 1'b0;
      #1;
      checks++;
      if (recv_rdy !== 1'b1 || send_val !== 1'b0 ||
          send_idx !== 3'd0 || send_mag !== '0) begin
         errors++;
         $display("FAIL midreset async: rdy=%b val=%b idx=%0d mag=%h, want 1 0 0 0",
                  recv_rdy, send_val, send_idx, send_mag);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      fr = '{32'h0010_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
             32'h0009_0000, 32'hFFF9_0000, 32'h0001_0000, 32'h0};
      send_frame();
      check_frame("midreset", 3'd4, 32'h0009_0000);
   endtask

   task automatic test_random();
      logic [W-1:0] cur [N];
      logic [2:0]   iq [$];
      logic [W-1:0] mq [$];
      logic [2:0]   ei;
      logic [W-1:0] em;
      logic [W-1:0] msg;
      logic         rdy;
      logic         sv;
      logic         srdy;
      logic [2:0]   oi;
      logic [W-1:0] om;
      int           pos  = 0;
      int           sent = 0;
      int           got  = 0;
      for (int cyc = 0; cyc < 20000 && got < 100; cyc++) begin
         msg      = rand_bin();
         recv_msg = msg;
         recv_val = (sent < 100) && ($urandom_range(0, 3) != 0);
         srdy     = ($urandom_range(0, 2) != 0);
         send_rdy = srdy;
         rdy = recv_rdy;
         sv  = send_val;
         oi  = send_idx;
         om  = send_mag;
         @(posedge clk);
         #1;
         if (recv_val && rdy) begin
            cur[pos] = msg;
            pos++;
            if (pos == N) begin
               model(cur, ei, em);
               iq.push_back(ei);
               mq.push_back(em);
               sent++;
               pos = 0;
            end
         end
         if (sv && srdy) begin
            got++;
            checks++;
            if (iq.size() == 0) begin
               errors++;
               $display("FAIL rand dup: result %0d idx=%0d mag=%h with none expected",
                        got, oi, om);
            end else begin
               ei = iq.pop_front();
               em = mq.pop_front();
               if (oi !== ei || om !== em) begin
                  errors++;
                  $display("FAIL rand frame %0d: got idx=%0d mag=%h, want idx=%0d mag=%h",
                           got, oi, om, ei, em);
               end
            end
         end
      end
      recv_val = 1'b0;
      send_rdy = 1'b0;
      checks++;
      if (got != 100 || iq.size() != 0) begin
         errors++;
         $display("FAIL rand count: got %0d results, %0d pending, want 100 0",
                  got, iq.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_saturation();
      test_backpressure();
      test_reset_mid_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_peak_collector.md
# fft_peak_collector

Receives the serialized FFT output stream (one `BIT_WIDTH`-bit signed fixed-point bin per transfer, `N_SAMPLES` bins per frame, bin 0 first) and reduces each frame to its dominant bin. It reports the bin index and magnitude over a val/rdy interface. It sits on the consuming end of the FFT harness's serial output port and is the frame-level counterpart of the harness's output serializer. It feeds the downstream classifier and control logic.

## Interface
- `BIT_WIDTH`, default 32: width of each incoming bin word, two's complement.
- `N_SAMPLES`, default 8: bins per frame; must be a power of two ≥ 2.
- `SKIP_DC`, default 1: when 1, bin 0 is consumed but excluded from the peak search.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Low means reset.
- `recv_msg` input, `BIT_WIDTH` bits: current bin value.
- `recv_val` input, 1 bit: `recv_msg` is valid.
- `recv_rdy` output, 1 bit: block accepts a bin this cycle.
- `send_idx` output, `$clog2(N_SAMPLES)` bits: index of the peak bin.
- `send_mag` output, `BIT_WIDTH` bits: absolute value of the peak bin, unsigned, same fixed-point scaling as the input.
- `send_val` output, 1 bit: result is valid.
- `send_rdy` input, 1 bit: downstream accepts the result.

## Operation
- States:
  - ACCUM: collecting bins.
  - DONE: holding the result.
- Registers:
  - `count`: `$clog2(N_SAMPLES)` bits.
  - `best_idx`, `best_mag`.
  - `have_best`: 1 bit.
- Output decode:
  - ACCUM: `recv_rdy`=1, `send_val`=0.
  - DONE: `recv_rdy`=0, `send_val`=1.
- Input transfer: a bin is accepted when `recv_val && recv_rdy` at a rising edge.
- Magnitude:
  - |x| = x if x ≥ 0, otherwise −x.
  - The most negative value 0x8000_0000 (for 32 bits) saturates to 0x7FFF_FFFF. Outputs never wrap.
- Candidate rule:
  - Every bin is a candidate except bin 0 when `SKIP_DC`=1.
  - The first candidate of a frame loads `best` unconditionally and sets `have_best`.
  - Later candidates replace `best` only if strictly greater, so ties keep the lowest index.
- On each transfer, `count` increments. The transfer with `count == N_SAMPLES-1`:
  - completes the candidate update using this bin,
  - clears `count` to 0,
  - clears `have_best`,
  - moves to DONE.
- In DONE, `send_idx` and `send_mag` come directly from the `best` registers and are stable while `send_val`=1.
- When `send_val && send_rdy` at a rising edge, the state returns to ACCUM. `best_*` may keep stale values until overwritten.
- An all-zero frame reports `idx` = first candidate (1 if `SKIP_DC`, else 0) with `mag` = 0.

## Timing
- Reset (`reset` low), asynchronous:
  - state = ACCUM; `count`=0; `have_best`=0; `best_idx`=0; `best_mag`=0.
  - Therefore `recv_rdy`=1, `send_val`=0, `send_idx`=0, `send_mag`=0, valid immediately while reset is low.
- Reset deasserted mid-frame: the partial frame is discarded and the next accepted bin is bin 0.
- Latency: `send_val` rises on the cycle after the edge that accepted the last bin.
- Throughput: 1 bin/cycle in ACCUM. Each result costs at least 1 DONE cycle with `recv_rdy`=0, so the minimum period is `N_SAMPLES`+1 cycles per frame.
- Backpressure: DONE holds indefinitely while `send_rdy`=0. `recv_val` is ignored in DONE and no bins are lost, because `recv_rdy`=0.
- Gaps: `recv_val`=0 cycles in ACCUM change no state. Frames may span any number of cycles.
- `recv_rdy` depends only on state, not combinationally on `recv_val` or `send_rdy`.
- `send_val` depends only on state, not combinationally on `send_rdy`.

## Test plan
- Reset: hold `reset` low for 3 cycles. Required: `recv_rdy`=1, `send_val`=0, `send_idx`=0, `send_mag`=0 during and after reset.
- Basic frame, `SKIP_DC`=1, N=8, back-to-back bins {0x00100000, 0x00010000, 0xFFFB0000, 0x00020000, 0, 0, 0x00030000, 0}:
  - Required: `send_val` on the cycle after the 8th bin, `send_idx`=2, `send_mag`=0x00050000.
  - Bin 0, though largest, is ignored.
- Tie and saturation:
  - Frame with bins 3 and 5 both 0x00040000 → `idx`=3.
  - Separate frame containing 0x80000000 at bin 6 → `idx`=6, `mag`=0x7FFFFFFF.
- Backpressure: hold `send_rdy`=0 for 10 cycles after result with `recv_val`=1 streaming.
  - Required: `recv_rdy`=0 throughout, result stable.
  - After `send_rdy`=1, the next frame's bin 0 is accepted on the following cycle and that frame reports correctly.
- Reset mid-frame: send 5 bins, pulse `reset` low for 1 cycle, then send a full frame with its peak at bin 4 = 0x00090000.
  - Required: `idx`=4, `mag`=0x00090000, no contribution from pre-reset bins.
- Randomized `recv_val` gaps and `send_rdy` stalls over 100 frames, checked against a golden model: every result matches and no frames are dropped or duplicated.
